lsu: RTL

Load/store unit: the initiator side of the NPC data-memory port. It accepts one load or store per handshake from the execute stage and drives a doubleword-aligned request to data memory. It then waits for the memory acknowledge, extracts and extends the addressed bytes, and returns one response per request to writeback. The block also flags misaligned accesses, times out requests the memory never acknowledges, and forwards the memory's difftest skip indication with each response.

---
 rtl/lsu.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// Load/store unit: initiator side of the data-memory port. Accepts one op per
// handshake, issues a doubleword-aligned request, and returns one response per op.
module lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_en,
  output logic        mem_w_en,
  output logic [63:0] mem_addr,
  output logic [3:0]  mem_w_width,
  output logic [7:0]  mem_wstrb,
  output logic [63:0] mem_w_data,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  input  logic        mem_skip,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_err,
  output logic        resp_skip
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [2:0]  off_q;
  logic [63:0] mem_addr_q;
  logic [63:0] mem_w_data_q;
  logic [7:0]  mem_wstrb_q;
  logic [3:0]  mem_w_width_q;
  logic [63:0] resp_data_q;
  logic [4:0]  resp_rd_q;
  logic        resp_err_q;
  logic        resp_skip_q;

  logic        misaligned;
  logic [7:0]  lane_mask;
  logic [63:0] shifted;
  logic [63:0] load_ext;

  // Alignment check and store lane mask for the incoming request
  always_comb begin
    misaligned = 1'b0;
    lane_mask  = 8'h01;
    case (req_size)
      2'd0: begin
        misaligned = 1'b0;
        lane_mask  = 8'h01;
      end
      2'd1: begin
        misaligned = req_addr[0];
        lane_mask  = 8'h03;
      end
      2'd2: begin
        misaligned = |req_addr[1:0];
        lane_mask  = 8'h0F;
      end
      default: begin
        misaligned = |req_addr[2:0];
        lane_mask  = 8'hFF;
      end
    endcase
  end

  // Right-align the addressed bytes of the returned doubleword and extend them
  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'd0:    load_ext = {{56{~unsigned_q & shifted[7]}}, shifted[7:0]};
      2'd1:    load_ext = {{48{~unsigned_q & shifted[15]}}, shifted[15:0]};
      2'd2:    load_ext = {{32{~unsigned_q & shifted[31]}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  // Next-state logic; ack takes priority over the timeout on the same cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid) state_d = misaligned ? StResp : StReq;
      StReq:   if (mem_ack || (cnt_q == TimeoutLast)) state_d = StResp;
      StResp:  if (resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Request latch, timeout counter and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      we_q          <= 1'b0;
      size_q        <= '0;
      unsigned_q    <= 1'b0;
      off_q         <= '0;
      mem_addr_q    <= '0;
      mem_w_data_q  <= '0;
      mem_wstrb_q   <= '0;
      mem_w_width_q <= '0;
      resp_data_q   <= '0;
      resp_rd_q     <= '0;
      resp_err_q    <= 1'b0;
      resp_skip_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            cnt_q         <= '0;
            we_q          <= req_we;
            size_q        <= req_size;
            unsigned_q    <= req_unsigned;
            off_q         <= req_addr[2:0];
            mem_addr_q    <= {req_addr[63:3], 3'b000};
            mem_w_data_q  <= req_wdata << {req_addr[2:0], 3'b000};
            mem_wstrb_q   <= req_we ? (lane_mask << req_addr[2:0]) : 8'h00;
            mem_w_width_q <= req_we ? (4'd1 << req_size) : 4'd0;
            resp_rd_q     <= req_rd;
            if (misaligned) begin
              resp_err_q  <= 1'b1;
              resp_data_q <= '0;
              resp_skip_q <= 1'b0;
            end
          end
        end
        StReq: begin
          if (mem_ack) begin
            resp_err_q  <= 1'b0;
            resp_data_q <= we_q ? 64'd0 : load_ext;
            resp_skip_q <= mem_skip;
          end else if (cnt_q == TimeoutLast) begin
            resp_err_q  <= 1'b1;
            resp_data_q <= '0;
            resp_skip_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign mem_en      = (state_q == StReq);
  assign mem_w_en    = mem_en & we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_w_width = mem_w_width_q;
  assign mem_wstrb   = mem_wstrb_q;
  assign mem_w_data  = mem_w_data_q;
  assign resp_valid  = (state_q == StResp);
  assign resp_data   = resp_data_q;
  assign resp_rd     = resp_rd_q;
  assign resp_err    = resp_err_q;
  assign resp_skip   = resp_skip_q;

endmodule
